// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over a req/ack memory
// handshake and presents one instruction at a time to decode (valid/ready).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

  localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;
  localparam logic [31:0] STEP    = 32'(PC_STEP);

  state_t      state, state_next;
  logic [31:0] target_al;
  logic [31:0] pc_next;
  logic        fetch_done;
  logic        load_addr;

  assign target_al  = redirect_target & ~32'h3;
  assign fetch_done = (state == REQ) && imem_ack && !redirect;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A request in flight cannot be withdrawn: a redirect without the ack
  // parks in DRAIN until the stale response arrives.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fetch_en) state_next = REQ;
      end
      REQ: begin
        if (redirect)      state_next = imem_ack ? REQ : DRAIN;
        else if (imem_ack) state_next = HOLD;
      end
      DRAIN: begin
        if (imem_ack) state_next = fetch_en ? REQ : IDLE;
      end
      HOLD: begin
        if (redirect || instr_ready) state_next = fetch_en ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == REQ) || (state == DRAIN);
    instr_valid = (state == HOLD);
  end

  always_comb begin
    pc_next = pc;
    if (redirect)        pc_next = target_al;
    else if (fetch_done) pc_next = pc + STEP;
  end

  // The address register is loaded only when a new request begins, so it
  // never moves while imem_req is asserted.
  assign load_addr = (state_next == REQ) && ((state != REQ) || imem_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= PC_INIT;
      imem_addr <= '0;
      instr     <= '0;
      instr_pc  <= '0;
    end else begin
      pc <= pc_next;
      if (load_addr) imem_addr <= pc_next;
      if (fetch_done) begin
        instr    <= imem_rdata;
        instr_pc <= imem_addr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, fetch_en, imem_ack, instr_ready, redirect;
  logic [31:0] imem_rdata, redirect_target;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc, pc;
  logic        w_imem_req, w_instr_valid;
  logic [31:0] w_imem_addr, w_instr, w_instr_pc, w_pc;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_target(redirect_target), .pc(pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(w_instr_valid), .instr_ready(instr_ready),
    .instr(w_instr), .instr_pc(w_instr_pc),
    .redirect(redirect), .redirect_target(redirect_target), .pc(w_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; fetch_en = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    redirect = 1'b0; imem_rdata = '0; redirect_target = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Assumes a request is pending; completes it and lets decode take it.
  task automatic fetch_one(input logic [31:0] data);
    imem_ack = 1'b1; imem_rdata = data;
    tick();
    imem_ack = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    total_cnt++;
    if ({imem_req, instr_valid} !== 2'b00)
      $display("FAIL reset_strobes: req/valid=%b want 00", {imem_req, instr_valid});
    else pass_cnt++;
    total_cnt++;
    if ({imem_addr, instr, instr_pc, pc} !== 128'h0)
      $display("FAIL reset_regs: addr=%h instr=%h ipc=%h pc=%h want all 0", imem_addr, instr, instr_pc, pc);
    else pass_cnt++;
    total_cnt++;
    if (w_pc !== 32'hFFFF_FFFC) $display("FAIL reset_wrap_pc: got %h want fffffffc", w_pc);
    else pass_cnt++;
  endtask

  task automatic test_fetch();
    fetch_en = 1'b1;
    tick();
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL fetch_req: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    else pass_cnt++;
    imem_ack = 1'b1; imem_rdata = 32'hE1A0_3231;
    tick();
    imem_ack = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b1 || instr !== 32'hE1A0_3231 || instr_pc !== 32'h0 || pc !== 32'h4)
      $display("FAIL fetch_data: v=%b instr=%h ipc=%h pc=%h want 1/e1a03231/0/4", instr_valid, instr, instr_pc, pc);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if ({imem_req, instr_valid} !== 2'b01 || instr !== 32'hE1A0_3231 || instr_pc !== 32'h0)
        $display("FAIL backpressure_hold: req/v=%b instr=%h ipc=%h want 01/e1a03231/0", {imem_req, instr_valid}, instr, instr_pc);
      else pass_cnt++;
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0)
      $display("FAIL backpressure_next: req=%b addr=%h v=%b want 1/4/0", imem_req, imem_addr, instr_valid);
    else pass_cnt++;
  endtask

  task automatic test_redirect_hold();
    fetch_one(32'hA000_0004);
    imem_ack = 1'b1; imem_rdata = 32'hA000_0008;
    tick();
    imem_ack = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h8)
      $display("FAIL redir_hold_pre: v=%b ipc=%h want 1/8", instr_valid, instr_pc);
    else pass_cnt++;
    redirect = 1'b1; redirect_target = 32'h0000_0103; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100 || pc !== 32'h100)
      $display("FAIL redir_hold: v=%b req=%b addr=%h pc=%h want 0/1/100/100", instr_valid, imem_req, imem_addr, pc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (instr_valid !== 1'b0) $display("FAIL redir_hold_discard: v=%b want 0", instr_valid);
    else pass_cnt++;
  endtask

  task automatic test_redirect_pending();
    reset_dut();
    fetch_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) fetch_one(32'hC000_0000 + 32'(i));
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC)
      $display("FAIL pend_pre: req=%b addr=%h want 1/c", imem_req, imem_addr);
    else pass_cnt++;
    redirect = 1'b1; redirect_target = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hC || pc !== 32'h200 || instr_valid !== 1'b0)
        $display("FAIL pend_drain: req=%b addr=%h pc=%h v=%b want 1/c/200/0", imem_req, imem_addr, pc, instr_valid);
      else pass_cnt++;
      if (i < 2) tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0)
      $display("FAIL pend_next: req=%b addr=%h v=%b want 1/200/0", imem_req, imem_addr, instr_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    redirect = 1'b1; redirect_target = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || pc !== 32'h300)
      $display("FAIL rstmid_pre: req=%b addr=%h pc=%h want 1/200/300", imem_req, imem_addr, pc);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0; fetch_en = 1'b0;
    total_cnt++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || imem_addr !== 32'h0)
      $display("FAIL rstmid: req=%b v=%b pc=%h addr=%h want 0/0/0/0", imem_req, instr_valid, pc, imem_addr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (imem_req !== 1'b0) $display("FAIL rstmid_idle: req=%b want 0", imem_req);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    reset_dut();
    fetch_en = 1'b1;
    tick();
    total_cnt++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_req: req=%b addr=%h want 1/fffffffc", w_imem_req, w_imem_addr);
    else pass_cnt++;
    imem_ack = 1'b1; imem_rdata = 32'h1357_9BDF;
    tick();
    imem_ack = 1'b0; fetch_en = 1'b0;
    total_cnt++;
    if (w_instr_valid !== 1'b1 || w_instr !== 32'h1357_9BDF || w_instr_pc !== 32'hFFFF_FFFC || w_pc !== 32'h0)
      $display("FAIL wrap: v=%b instr=%h ipc=%h pc=%h want 1/13579bdf/fffffffc/0", w_instr_valid, w_instr, w_instr_pc, w_pc);
    else pass_cnt++;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  // Reference model tracks transactions: the architectural next PC, the
  // outstanding memory request (and whether a redirect made it stale), and
  // the instruction held for decode.
  task automatic test_random();
    logic [31:0] m_pc, m_req_addr, m_instr, m_ipc;
    logic        m_req, m_stale, m_valid, was_req, was_valid, refetch;
    reset_dut();
    m_pc = 32'h0; m_req = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
    m_req_addr = '0; m_instr = '0; m_ipc = '0;
    for (int i = 0; i < 4000; i++) begin
      total_cnt++;
      if (pc !== m_pc || imem_req !== m_req || instr_valid !== m_valid ||
          (m_req && imem_addr !== m_req_addr) ||
          (m_valid && (instr !== m_instr || instr_pc !== m_ipc)))
        $display("FAIL rand_cycle%0d: pc=%h req=%b addr=%h v=%b instr=%h ipc=%h want pc=%h req=%b addr=%h v=%b instr=%h ipc=%h",
                 i, pc, imem_req, imem_addr, instr_valid, instr, instr_pc,
                 m_pc, m_req, m_req_addr, m_valid, m_instr, m_ipc);
      else pass_cnt++;

      reset           = ($urandom_range(0, 299) == 0);
      fetch_en        = ($urandom_range(0, 3) != 0);
      imem_ack        = ($urandom_range(0, 2) == 0);
      imem_rdata      = $urandom;
      instr_ready     = ($urandom_range(0, 1) == 0);
      redirect        = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom;
      @(posedge clk);
      if (reset) begin
        m_pc = 32'h0; m_req = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
      end else begin
        was_req = m_req; was_valid = m_valid; refetch = 1'b0;
        if (was_valid && (redirect || instr_ready)) m_valid = 1'b0;
        if (was_req) begin
          if (imem_ack) begin
            m_req = 1'b0;
            if (!m_stale && !redirect) begin
              m_valid = 1'b1; m_instr = imem_rdata; m_ipc = m_req_addr;
              m_pc = m_pc + 32'd4;
            end else if (!m_stale) refetch = 1'b1;
          end else if (redirect) m_stale = 1'b1;
        end
        if (redirect) m_pc = {redirect_target[31:2], 2'b00};
        if (!m_req && !m_valid && (fetch_en || refetch)) begin
          m_req = 1'b1; m_stale = 1'b0; m_req_addr = m_pc;
        end
      end
      #1;
    end
    reset = 1'b0; imem_ack = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_redirect_hold();
    test_redirect_pending();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
